pll_phs_port_arbiter: RTL and testbench
=======================================

# pll_phs_port_arbiter

Round-robin arbiter that lets up to NUM_REQ BCLK/SCLK alignment engines share one PLL dynamic phase-shift port (rotate, loadphs_b, bclk/bclk90 select, direction). It sits between the per-bank alignment engines and the PLL. It grants the port to one engine for a complete training session and enforces an idle gap between sessions. An optional watchdog revokes a grant whose owner stops driving the port.

## Interface
- NUM_REQ, 4, number of requesters, legal 2..8.
- GAP_CYCLES, 4, idle sclk cycles forced between grants, legal 1..15.
- TIMEOUT_CYCLES, 4095, consecutive inactive grant cycles before revocation, legal 16..4095.
- sclk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  session request per engine; held high for the whole session.
- rotate_in  in  NUM_REQ  per-engine vcophsel_rotate.
- loadphs_b_in  in  NUM_REQ  per-engine loadphs_b, active low.
- bclk_sel_in  in  NUM_REQ  per-engine vcophsel_bclk_sel.
- bclk90_sel_in  in  NUM_REQ  per-engine vcophsel_bclk90_sel.
- dir_in  in  NUM_REQ  per-engine vcophsel_dir.
- clr_err  in  1  synchronous clear of timeout_err.
- gnt  out  NUM_REQ  one-hot grant, registered; reset 0.
- owner_id  out  3  index of current or last owner; reset 0.
- busy  out  1  high in GRANT or GAP; reset 0.
- vcophsel_rotate  out  1  to PLL; reset 0.
- loadphs_b  out  1  to PLL; reset 1.
- vcophsel_bclk_sel, vcophsel_bclk90_sel  out  1 each  to PLL; reset 0.
- vcophsel_dir  out  1  to PLL; reset 1.
- timeout_err  out  NUM_REQ  sticky per-requester timeout flag; reset 0 (present only with the watchdog macro).

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if any eligible req bit is set, the round-robin picker selects the winner. The search starts at (owner_id+1) mod NUM_REQ. On the next edge the FSM enters GRANT, sets gnt[winner], and sets owner_id=winner. An eligible req is one that is high and not masked.
- GRANT: PLL outputs are a combinational mux of the owner's *_in bits with zero latency. The FSM leaves GRANT when req[owner] falls. On that edge gnt clears and the FSM enters GAP.
- GAP: PLL outputs are parked at the idle values (rotate 0, loadphs_b 1, sels 0, dir 1). After GAP_CYCLES cycles the FSM returns to IDLE. Requests arriving during GAP wait in the queue.
- Outside GRANT, PLL outputs are always at the idle values.
- The owner is never pre-empted by a higher-index or lower-index request.
- Watchdog, active only with the macro:
  - In GRANT a counter clears on any owner activity (rotate_in=1 or loadphs_b_in=0) and increments otherwise.
  - When the count reaches TIMEOUT_CYCLES: gnt clears, timeout_err[owner] is set, mask[owner] is set, and the FSM enters GAP.
  - mask[i] clears when req[i] is low. A revoked engine must drop req before it can re-request.
- Simultaneous release and timeout on the same edge: treated as a normal release; no error is set.
- clr_err and a new timeout on the same edge: set wins.
- A req for a non-owner that falls while waiting has no effect.

## Timing
- Arbitration latency: req rising in IDLE produces gnt on the next edge (1 cycle).
- Release: gnt falls 1 cycle after req[owner] falls. The next gnt appears no earlier than GAP_CYCLES+1 cycles after that.
- PLL outputs follow the owner's inputs combinationally while gnt is high. They are forced to idle in the same cycle gnt deasserts.
- Reset asserted mid-session: gnt, busy, and the FSM clear asynchronously, and PLL outputs go to idle at once. After reset deassertion, the round-robin start index is 0.

## Configuration
- PLL_PHS_ARB_TIMEOUT_EN defined: the watchdog counter, mask, timeout_err, and clr_err logic are built.
- PLL_PHS_ARB_TIMEOUT_EN undefined: no watchdog; a grant ends only on req release. The timeout_err port is driven to 0, and clr_err is ignored.

## Structure
- Shared package pll_phs_arb_pkg holds:
  - state enumeration (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - idle-value constants for the PLL port;
  - the owner_id width constant (3).
- Sub-module pll_phs_rr_pick: combinational round-robin picker. Inputs are the eligible vector and the start index; outputs are a one-hot winner and its index.

## Test plan
- Single request: req=4'b0010, bursts of rotate_in[1] -> gnt=4'b0010 one cycle later; vcophsel_rotate mirrors rotate_in[1]; after req drops, busy stays high for 4 cycles, then returns low.
- Contention: req=4'b1111 held, each engine releasing after 20 cycles -> grant order 0,1,2,3,0 with exactly 4 idle gap cycles between grants.
- Isolation: a non-owner toggles rotate_in and loadphs_b_in during another engine's grant -> PLL outputs are unaffected; loadphs_b=1 in GAP.
- Watchdog (macro on, TIMEOUT_CYCLES=16): the owner holds req with no activity -> gnt drops after 16 cycles and timeout_err[owner]=1; the same engine is not re-granted until its req toggles low; clr_err clears the flag.
- Boundary: release and timeout on the same cycle -> no error set; reset_n pulsed mid-grant -> gnt=0, loadphs_b=1, and the first grant after reset goes to index 0 when all requests are high.

Source files
------------

// File: rtl/pll_phs_port_arbiter_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift port arbiter.
package pll_phs_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int OWNER_W = 3;
    localparam int GAP_W   = 4;
    localparam int TMO_W   = 12;

    // Values the PLL port is parked at whenever no engine owns it
    localparam logic IDLE_ROTATE     = 1'b0;
    localparam logic IDLE_LOADPHS_B  = 1'b1;
    localparam logic IDLE_BCLK_SEL   = 1'b0;
    localparam logic IDLE_BCLK90_SEL = 1'b0;
    localparam logic IDLE_DIR        = 1'b1;

endpackage

// File: rtl/pll_phs_port_arbiter_if.sv
// Engine-side request/phase-shift bundle and PLL-side port of the arbiter.
interface pll_phs_port_arbiter_if
    import pll_phs_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rotate_in;
    logic [NUM_REQ-1:0] loadphs_b_in;
    logic [NUM_REQ-1:0] bclk_sel_in;
    logic [NUM_REQ-1:0] bclk90_sel_in;
    logic [NUM_REQ-1:0] dir_in;
    logic               clr_err;

    logic [NUM_REQ-1:0] gnt;
    logic [OWNER_W-1:0] owner_id;
    logic               busy;
    logic               vcophsel_rotate;
    logic               loadphs_b;
    logic               vcophsel_bclk_sel;
    logic               vcophsel_bclk90_sel;
    logic               vcophsel_dir;
    logic [NUM_REQ-1:0] timeout_err;

    modport master (
        output req, rotate_in, loadphs_b_in, bclk_sel_in, bclk90_sel_in, dir_in, clr_err,
        input  gnt, owner_id, busy, vcophsel_rotate, loadphs_b,
               vcophsel_bclk_sel, vcophsel_bclk90_sel, vcophsel_dir, timeout_err
    );

    modport slave (
        input  req, rotate_in, loadphs_b_in, bclk_sel_in, bclk90_sel_in, dir_in, clr_err,
        output gnt, owner_id, busy, vcophsel_rotate, loadphs_b,
               vcophsel_bclk_sel, vcophsel_bclk90_sel, vcophsel_dir, timeout_err
    );

endinterface

// File: rtl/pll_phs_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after i_start, wrapping.
module pll_phs_rr_pick
    import pll_phs_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [OWNER_W-1:0] i_start,
    output logic [NUM_REQ-1:0] o_gnt_1h,
    output logic [OWNER_W-1:0] o_idx,
    output logic               o_vld
);

    logic [NUM_REQ-1:0] w_rot;
    logic [OWNER_W:0]   w_off;
    logic [OWNER_W:0]   w_sum;

    // Rotate so that bit 0 is the start index; lowest set bit is then the winner
    assign w_rot = NUM_REQ'({i_elig, i_elig} >> i_start);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (OWNER_W + 1)'(k);
            end
        end
    end

    assign w_sum    = {1'b0, i_start} + w_off;
    assign o_idx    = (w_sum >= (OWNER_W + 1)'(NUM_REQ)) ?
                      OWNER_W'(w_sum - (OWNER_W + 1)'(NUM_REQ)) : OWNER_W'(w_sum);
    assign o_vld    = |i_elig;
    assign o_gnt_1h = o_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule

// File: rtl/pll_phs_port_arbiter.sv
// Round-robin owner of the PLL dynamic phase-shift port with a forced idle gap between sessions.
// Optional grant watchdog built when PLL_PHS_ARB_TIMEOUT_EN is defined.
module pll_phs_port_arbiter
    import pll_phs_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                   sclk,
    input  logic                   reset_n,
    pll_phs_port_arbiter_if.slave  phs
);

    // state | meaning
    // IDLE  | port parked, picker arbitrates eligible requests
    // GRANT | owner's phase-shift bits pass straight to the PLL
    // GAP   | port parked for GAP_CYCLES before the next arbitration

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;

    logic [NUM_REQ-1:0] r_gnt;
    logic [OWNER_W-1:0] r_owner;
    logic               r_first;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_pick_1h;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_vld;
    logic [OWNER_W:0]   w_owner_inc;
    logic [OWNER_W-1:0] w_start;
    logic               w_own_req;
    logic               w_own_act;
    logic               w_wdog_hit;
    logic               w_release;
    logic               w_revoke;

    assign w_own_req   = |(phs.req & r_gnt);
    assign w_own_act   = (|(phs.rotate_in & r_gnt)) | (|(~phs.loadphs_b_in & r_gnt));
    assign w_owner_inc = {1'b0, r_owner} + (OWNER_W + 1)'(1);

    // Until the first grant after reset the search starts at index 0
    assign w_start = (r_first || (w_owner_inc >= (OWNER_W + 1)'(NUM_REQ))) ?
                     '0 : w_owner_inc[OWNER_W-1:0];

    assign w_release = (r_state == ST_GRANT) && !w_own_req;
    assign w_revoke  = (r_state == ST_GRANT) && w_own_req && w_wdog_hit;

`ifdef PLL_PHS_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]   r_wdog_cnt;
    logic [NUM_REQ-1:0] r_mask;
    logic [NUM_REQ-1:0] r_terr;

    assign w_wdog_hit = (r_state == ST_GRANT) && !w_own_act &&
                        (r_wdog_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_elig     = phs.req & ~r_mask;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog_cnt <= '0;
            r_mask     <= '0;
            r_terr     <= '0;
        end else begin
            if ((r_state != ST_GRANT) || w_own_act) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + TMO_W'(1);
            end
            r_mask <= (r_mask & phs.req) | (w_revoke ? r_gnt : '0);
            // A new timeout overrides a clear on the same edge
            r_terr <= (phs.clr_err ? '0 : r_terr) | (w_revoke ? r_gnt : '0);
        end
    end

    assign phs.timeout_err = r_terr;
`else
    logic w_unused_clr_err;

    assign w_wdog_hit       = 1'b0;
    assign w_elig           = phs.req;
    assign w_unused_clr_err = phs.clr_err;
    assign phs.timeout_err  = '0;
`endif

    pll_phs_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_elig   (w_elig),
        .i_start  (w_start),
        .o_gnt_1h (w_pick_1h),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_vld)              w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release || w_revoke)   w_state_nxt = ST_GAP;
            ST_GAP:   if (r_gap_cnt == '0)         w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt     <= '0;
            r_owner   <= '0;
            r_first   <= 1'b1;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt   <= w_pick_1h;
                        r_owner <= w_pick_idx;
                        r_first <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_revoke) begin
                        r_gnt     <= '0;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        phs.busy                = (r_state != ST_IDLE);
        phs.vcophsel_rotate     = IDLE_ROTATE;
        phs.loadphs_b           = IDLE_LOADPHS_B;
        phs.vcophsel_bclk_sel   = IDLE_BCLK_SEL;
        phs.vcophsel_bclk90_sel = IDLE_BCLK90_SEL;
        phs.vcophsel_dir        = IDLE_DIR;
        if (r_state == ST_GRANT) begin
            phs.vcophsel_rotate     = |(phs.rotate_in     & r_gnt);
            phs.loadphs_b           = |(phs.loadphs_b_in  & r_gnt);
            phs.vcophsel_bclk_sel   = |(phs.bclk_sel_in   & r_gnt);
            phs.vcophsel_bclk90_sel = |(phs.bclk90_sel_in & r_gnt);
            phs.vcophsel_dir        = |(phs.dir_in        & r_gnt);
        end
    end

    assign phs.gnt      = r_gnt;
    assign phs.owner_id = r_owner;

endmodule

// File: tb/tb_pll_phs_port_arbiter.sv
// Directed bench for pll_phs_port_arbiter (NUM_REQ=4, GAP_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_pll_phs_port_arbiter;

    logic sclk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    pll_phs_port_arbiter_if #(.NUM_REQ(4)) phs_if ();

    pll_phs_port_arbiter #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sclk    (sclk),
        .reset_n (reset_n),
        .phs     (phs_if)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_gnt(input int budget, output int n);
        n = 0;
        while (phs_if.gnt == '0 && n < budget) begin
            step();
            n++;
        end
        if (phs_if.gnt == '0) chk("wait_gnt_expired", 32'd0, 32'd1);
    endtask

    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int n;
    int own;
    int cnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n              = 1'b0;
        phs_if.req           = '0;
        phs_if.rotate_in     = '0;
        phs_if.loadphs_b_in  = 4'hF;
        phs_if.bclk_sel_in   = '0;
        phs_if.bclk90_sel_in = '0;
        phs_if.dir_in        = '0;
        phs_if.clr_err       = 1'b0;
        repeat (2) step();

        chk("rst_gnt",      phs_if.gnt, 0);
        chk("rst_owner",    phs_if.owner_id, 0);
        chk("rst_busy",     phs_if.busy, 0);
        chk("rst_rotate",   phs_if.vcophsel_rotate, 0);
        chk("rst_loadphs",  phs_if.loadphs_b, 1);
        chk("rst_bclk",     phs_if.vcophsel_bclk_sel, 0);
        chk("rst_bclk90",   phs_if.vcophsel_bclk90_sel, 0);
        chk("rst_dir",      phs_if.vcophsel_dir, 1);
        chk("rst_terr",     phs_if.timeout_err, 0);
        reset_n = 1'b1;

        // Contention: all four request, owners keep loadphs_b low so they stay active
        phs_if.loadphs_b_in = 4'h0;
        phs_if.req          = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(20, n);
            chk("cont_latency", n, 1);
            chk("cont_gnt",     phs_if.gnt, 32'd1 << exp_ord[i]);
            chk("cont_owner",   phs_if.owner_id, exp_ord[i]);
            chk("cont_loadphs", phs_if.loadphs_b, 0);
            repeat (19) step();
            own = exp_ord[i];
            phs_if.req[own] = 1'b0;
            step();
            chk("cont_rel_gnt",     phs_if.gnt, 0);
            chk("cont_gap_loadphs", phs_if.loadphs_b, 1);
            if (i < 4) phs_if.req[own] = 1'b1;
            else       phs_if.req = '0;
            cnt = 0;
            while (phs_if.busy && phs_if.gnt == '0 && cnt < 20) begin
                cnt++;
                step();
            end
            chk("cont_gap_len", cnt, 4);
        end
        chk("cont_end_busy", phs_if.busy, 0);
        phs_if.loadphs_b_in = 4'hF;

        // Single request from engine 1, mux and isolation
        phs_if.req = 4'b0010;
        wait_gnt(10, n);
        chk("single_latency", n, 1);
        chk("single_gnt",     phs_if.gnt, 4'b0010);
        chk("single_owner",   phs_if.owner_id, 1);
        chk("single_busy",    phs_if.busy, 1);
        phs_if.rotate_in[1] = 1'b1;
        #1 chk("single_rot_hi", phs_if.vcophsel_rotate, 1);
        phs_if.rotate_in[1] = 1'b0;
        #1 chk("single_rot_lo", phs_if.vcophsel_rotate, 0);
        phs_if.bclk_sel_in[1]   = 1'b1;
        phs_if.bclk90_sel_in[1] = 1'b1;
        phs_if.dir_in           = 4'b1101;
        #1;
        chk("single_bclk",   phs_if.vcophsel_bclk_sel, 1);
        chk("single_bclk90", phs_if.vcophsel_bclk90_sel, 1);
        chk("single_dir",    phs_if.vcophsel_dir, 0);
        phs_if.rotate_in    = 4'b1101;
        phs_if.loadphs_b_in = 4'b0010;
        #1;
        chk("iso_rotate",  phs_if.vcophsel_rotate, 0);
        chk("iso_loadphs", phs_if.loadphs_b, 1);
        step();
        phs_if.loadphs_b_in[1] = 1'b0;
        #1 chk("single_loadphs_lo", phs_if.loadphs_b, 0);
        phs_if.req[1] = 1'b0;
        step();
        chk("single_rel_gnt",  phs_if.gnt, 0);
        chk("gap_loadphs",     phs_if.loadphs_b, 1);
        chk("gap_rotate",      phs_if.vcophsel_rotate, 0);
        chk("gap_dir",         phs_if.vcophsel_dir, 1);
        chk("gap_bclk",        phs_if.vcophsel_bclk_sel, 0);
        cnt = 0;
        while (phs_if.busy && cnt < 20) begin
            cnt++;
            step();
        end
        chk("single_busy_len", cnt, 4);
        chk("single_last_owner", phs_if.owner_id, 1);
        phs_if.rotate_in     = '0;
        phs_if.loadphs_b_in  = 4'hF;
        phs_if.bclk_sel_in   = '0;
        phs_if.bclk90_sel_in = '0;
        phs_if.dir_in        = '0;

`ifdef PLL_PHS_ARB_TIMEOUT_EN
        // Engine 2 holds req with no activity
        phs_if.req = 4'b0100;
        wait_gnt(10, n);
        chk("wd_gnt", phs_if.gnt, 4'b0100);
        cnt = 0;
        while (phs_if.gnt != '0 && cnt < 40) begin
            cnt++;
            step();
        end
        chk("wd_gnt_len", cnt, 16);
        chk("wd_terr",    phs_if.timeout_err, 4'b0100);
        chk("wd_busy",    phs_if.busy, 1);
        repeat (10) step();
        chk("wd_masked_gnt",  phs_if.gnt, 0);
        chk("wd_masked_busy", phs_if.busy, 0);
        phs_if.clr_err = 1'b1;
        step();
        phs_if.clr_err = 1'b0;
        chk("wd_clr", phs_if.timeout_err, 0);
        phs_if.req = 4'b0000;
        step();
        phs_if.req = 4'b0100;
        wait_gnt(10, n);
        chk("wd_regrant", phs_if.gnt, 4'b0100);
        // Release on the very edge the watchdog would fire
        repeat (15) step();
        phs_if.req = 4'b0000;
        step();
        chk("wd_same_gnt",  phs_if.gnt, 0);
        chk("wd_same_terr", phs_if.timeout_err, 0);
        chk("wd_same_busy", phs_if.busy, 1);
        repeat (6) step();
`else
        phs_if.req = 4'b0100;
        wait_gnt(10, n);
        chk("nowd_gnt", phs_if.gnt, 4'b0100);
        phs_if.clr_err = 1'b1;
        repeat (30) step();
        phs_if.clr_err = 1'b0;
        chk("nowd_hold", phs_if.gnt, 4'b0100);
        chk("nowd_terr", phs_if.timeout_err, 0);
        phs_if.req = 4'b0000;
        repeat (6) step();
        chk("nowd_idle", phs_if.busy, 0);
`endif

        // Reset mid-grant: round-robin would pick 3, after reset it must pick 0
        phs_if.loadphs_b_in = 4'h0;
        phs_if.req          = 4'hF;
        wait_gnt(10, n);
        chk("prerst_gnt", phs_if.gnt, 4'b1000);
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk("midrst_gnt",     phs_if.gnt, 0);
        chk("midrst_busy",    phs_if.busy, 0);
        chk("midrst_loadphs", phs_if.loadphs_b, 1);
        chk("midrst_owner",   phs_if.owner_id, 0);
        step();
        reset_n = 1'b1;
        wait_gnt(10, n);
        chk("postrst_latency", n, 1);
        chk("postrst_gnt",     phs_if.gnt, 4'b0001);
        phs_if.req          = '0;
        phs_if.loadphs_b_in = 4'hF;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
